// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-queue bus: imem request port, redirect and core-side queue head
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_ack_i;
  logic [31:0]   imem_rdata_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          deq_i;
  logic          valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_plus4_o;
  logic [CW-1:0] count_o;

  modport slave (
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus4_o, count_o,
    input  imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, deq_i
  );

  modport master (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus4_o, count_o,
    output imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, deq_i
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC generator, single-outstanding imem port and prefetch FIFO feeding IF/ID
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  instr_fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          r_req;
  logic [31:0]   r_addr;
  logic          r_drop;
  logic [31:0]   r_pend_pc;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc4   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_valid;
  logic          w_ack;
  logic          w_deq;
  logic          w_enq;
  logic [31:0]   w_addr_p4;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_count_next;

  assign w_valid      = (r_count != '0);
  assign w_ack        = r_req & bus.imem_ack_i;
  assign w_deq        = bus.deq_i & w_valid;
  assign w_enq        = w_ack & ~r_drop & ~bus.redirect_i;
  assign w_addr_p4    = r_addr + 32'd4;
  assign w_redir_pc   = bus.redirect_pc_i & ~32'h3;
  assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_drop    <= 1'b0;
      r_pend_pc <= 32'h0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else if (bus.redirect_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      if (!r_req || w_ack) begin
        r_addr <= w_redir_pc;
        r_req  <= 1'b1;
        r_drop <= 1'b0;
      end else begin
        // Request still in flight: let it finish, then discard it and jump.
        r_drop    <= 1'b1;
        r_pend_pc <= w_redir_pc;
      end
    end else begin
      if (w_enq) begin
        r_instr[r_wptr] <= bus.imem_rdata_i;
        r_pc4[r_wptr]   <= w_addr_p4;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      if (w_ack && r_drop) begin
        r_drop <= 1'b0;
        r_addr <= r_pend_pc;
        r_req  <= 1'b1;
      end else if (!(r_req && !w_ack)) begin
        // Issue only if the slot this request will fill is guaranteed free.
        if (w_enq) begin
          r_addr <= w_addr_p4;
        end
        r_req <= (w_count_next < DEPTH_C);
      end
    end
  end

  assign bus.imem_req_o  = r_req;
  assign bus.imem_addr_o = r_addr;
  assign bus.valid_o     = w_valid;
  assign bus.instr_o     = w_valid ? r_instr[r_rptr] : 32'h0;
  assign bus.pc_plus4_o  = w_valid ? r_pc4[r_rptr] : 32'h0;
  assign bus.count_o     = r_count;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed vector bench for instr_fetch_queue
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(4)) ifc ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  // Memory model: each word holds its own address offset by a fixed tag.
  assign ifc.imem_rdata_i = ifc.imem_addr_o + 32'h1000_0000;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        deq;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic r, input logic a, input logic rd, input logic [31:0] rpc,
                     input logic d, input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep, input logic [2:0] ec);
    vec_t v;
    v.rst = r; v.ack = a; v.redir = rd; v.rpc = rpc; v.deq = d;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep; v.e_count = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic rd, input logic [31:0] rpc, input logic d);
    rst = r; ifc.imem_ack_i = a; ifc.redirect_i = rd; ifc.redirect_pc_i = rpc; ifc.deq_i = d;
  endtask

  task automatic check_all(input int idx, input logic eq, input logic [31:0] ea, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep, input logic [2:0] ec);
    chk("req",   idx, {31'h0, ifc.imem_req_o}, {31'h0, eq});
    chk("addr",  idx, ifc.imem_addr_o, ea);
    chk("valid", idx, {31'h0, ifc.valid_o}, {31'h0, ev});
    chk("instr", idx, ifc.instr_o, ei);
    chk("pc4",   idx, ifc.pc_plus4_o, ep);
    chk("count", idx, {29'h0, ifc.count_o}, {29'h0, ec});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming from reset with deq held high.
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,1,          1,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,1,          1,32'h4,1,32'h1000_0000,32'h4,1);
    add(0,1,0,32'h0,1,          1,32'h8,1,32'h1000_0004,32'h8,1);
    add(0,1,0,32'h0,1,          1,32'hC,1,32'h1000_0008,32'hC,1);
    // Fill to full, stall, then one dequeue releases one request.
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h4,1,32'h1000_0000,32'h4,1);
    add(0,1,0,32'h0,0,          1,32'h8,1,32'h1000_0000,32'h4,2);
    add(0,1,0,32'h0,0,          1,32'hC,1,32'h1000_0000,32'h4,3);
    add(0,1,0,32'h0,0,          0,32'h10,1,32'h1000_0000,32'h4,4);
    add(0,1,0,32'h0,0,          0,32'h10,1,32'h1000_0000,32'h4,4);
    add(0,1,0,32'h0,1,          1,32'h10,1,32'h1000_0004,32'h8,3);
    add(0,0,0,32'h0,0,          1,32'h10,1,32'h1000_0004,32'h8,3);
    // Redirect coinciding with ack and deq: flush, refetch from 0x40.
    add(0,1,1,32'h40,1,         1,32'h40,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h44,1,32'h1000_0040,32'h44,1);
    // Redirect during an unacked request; low target bits forced to zero.
    add(0,0,0,32'h0,1,          1,32'h44,0,32'h0,32'h0,0);
    add(0,0,1,32'h83,0,         1,32'h44,0,32'h0,32'h0,0);
    add(0,0,0,32'h0,0,          1,32'h44,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h80,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h84,1,32'h1000_0080,32'h84,1);
    // Reset mid-wait with two entries queued; late ack ignored.
    add(0,1,0,32'h0,0,          1,32'h88,1,32'h1000_0080,32'h84,2);
    add(0,0,0,32'h0,0,          1,32'h88,1,32'h1000_0080,32'h84,2);
    add(1,1,0,32'h0,0,          0,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h4,1,32'h1000_0000,32'h4,1);
    // Address wrap at the top of the 32-bit space.
    add(0,1,1,32'hFFFF_FFFC,1,  1,32'hFFFF_FFFC,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h0,1,32'h0FFF_FFFC,32'h0,1);
    // Second redirect overwrites the pending target.
    add(0,0,0,32'h0,1,          1,32'h0,0,32'h0,32'h0,0);
    add(0,0,1,32'h200,0,        1,32'h0,0,32'h0,32'h0,0);
    add(0,0,1,32'h300,0,        1,32'h0,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h300,0,32'h0,32'h0,0);
    add(0,1,0,32'h0,0,          1,32'h304,1,32'h1000_0300,32'h304,1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].redir, vecs[i].rpc, vecs[i].deq);
      @(posedge clk); #1;
      check_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_count);
    end

    // Sustained enq+deq: pointers wrap several times, one instr per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      @(posedge clk); #1;
      check_all(100 + i, 1'b1, 32'h308 + 32'(4*i), 1'b1,
                32'h1000_0304 + 32'(4*i), 32'h308 + 32'(4*i), 3'd1);
    end

    // Three-cycle ack latency: request held stable, data arrives in order.
    for (int r = 0; r < 2; r++) begin
      logic [31:0] a;
      a = 32'h32C + 32'(4*r);
      for (int w = 0; w < 3; w++) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        check_all(200 + 10*r + w, 1'b1, a, 1'b0, 32'h0, 32'h0, 3'd0);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      check_all(200 + 10*r + 3, 1'b1, a + 32'h4, 1'b1, a + 32'h1000_0000, a + 32'h4, 3'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
